// File: rtl/fa_pkg.sv
// -----------------------------------------------------------------------------
// fa_pkg
// Shared definitions for the full-adder checker:
//   VEC_W / ERR_W  : widths of the vector index and the error counter
//   ERR_MAX        : largest error count a run can produce (one per vector)
//   LAST_VEC       : index of the final vector of a run
//   fa_state_t     : checker FSM state encoding (IDLE / RUN / DONE)
//   fa_expected()  : golden {carry,sum} for a vector {a,b,cin}
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package fa_pkg;

    localparam int VEC_W = 3;
    localparam int ERR_W = 4;

    localparam logic [ERR_W-1:0] ERR_MAX  = 4'd8;
    localparam logic [VEC_W-1:0] LAST_VEC = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fa_state_t;

    // Arithmetic sum of the three operand bits, returned as {carry,sum}.
    function automatic logic [1:0] fa_expected(input logic [VEC_W-1:0] vec);
        logic [1:0] w_total;
        w_total = {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
        return w_total;
    endfunction

endpackage : fa_pkg

// File: rtl/full_adder_checker_if.sv
// -----------------------------------------------------------------------------
// full_adder_checker_if
// Bus between the checker and the single-bit full adder under test.
//   a, b, cin  : stimulus, driven by the checker
//   sum, carry : response, driven by the adder
// Modports:
//   master : checker side (drives stimulus, receives response)
//   slave  : adder side   (receives stimulus, drives response)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface full_adder_checker_if;

    logic a;
    logic b;
    logic cin;
    logic sum;
    logic carry;

    modport master (
        output a,
        output b,
        output cin,
        input  sum,
        input  carry
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output sum,
        output carry
    );

endinterface : full_adder_checker_if

// File: rtl/fa_vector_gen.sv
// -----------------------------------------------------------------------------
// fa_vector_gen
// Vector counter plus settle timer for the full-adder checker.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   i_load     : restart at vector 0 with a fresh settle period
//   i_run      : advance the settle timer / vector counter
//   o_vec      : current vector index {a,b,cin} (registered)
//   o_sample   : this cycle is the last held cycle of the current vector;
//                the response is sampled on the edge that ends it
//   o_last     : current vector is the final one (7)
// Parameter:
//   SETTLE_CYCLES : cycles each vector is held (>= 1)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module fa_vector_gen
    import fa_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_run,
    output logic [VEC_W-1:0] o_vec,
    output logic             o_sample,
    output logic             o_last
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [VEC_W-1:0] r_vec;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sample;

    // The timer counts the remaining held cycles of the current vector,
    // from SETTLE_CYCLES down to 1; the cycle in which it reads 1 is the
    // last held cycle.
    assign w_sample = i_run && (r_cnt == CNT_ONE);

    // After vector 7 the counter wraps to 0, so the stimulus returns to
    // 000 in DONE without any extra clearing logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec <= '0;
            r_cnt <= CNT_LOAD;
        end else if (i_load) begin
            r_vec <= '0;
            r_cnt <= CNT_LOAD;
        end else if (w_sample) begin
            r_vec <= r_vec + VEC_W'(1);
            r_cnt <= CNT_LOAD;
        end else if (i_run) begin
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    assign o_vec    = r_vec;
    assign o_sample = w_sample;
    assign o_last   = (r_vec == LAST_VEC);

endmodule : fa_vector_gen

// File: rtl/full_adder_checker.sv
// -----------------------------------------------------------------------------
// full_adder_checker
// Exhaustive stimulus/response checker for a single-bit full adder. Drives
// the eight vectors {a,b,cin} = 000..111, compares {carry,sum} against the
// arithmetic result and reports the outcome.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin a run (honoured in IDLE and DONE only)
//   bus               : adder bus (master side: a/b/cin out, sum/carry in)
//   busy              : run in progress
//   done              : run complete, held until next start or reset
//   pass              : done with zero mismatches
//   err_count         : mismatching vectors in the last run (0..8)
//   first_fail_vec    : index {a,b,cin} of the first mismatch
//   first_fail_valid  : first_fail_vec holds a captured index
// Parameter:
//   SETTLE_CYCLES     : cycles each vector is held before sampling (>= 1)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module full_adder_checker
    import fa_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    full_adder_checker_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      err_count,
    output logic [VEC_W-1:0]      first_fail_vec,
    output logic                  first_fail_valid
);

    fa_state_t        r_state;
    fa_state_t        w_state_nxt;

    logic             w_load;
    logic             w_run;
    logic [VEC_W-1:0] w_vec;
    logic             w_sample;
    logic             w_last;
    logic             w_finish;

    logic [1:0]       w_expected;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_inc;
    logic [ERR_W-1:0] w_err_nxt;

    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err_count;
    logic [VEC_W-1:0] r_first_fail_vec;
    logic             r_first_fail_valid;

    // start is only honoured outside RUN; a pulse mid-run is dropped.
    assign w_load   = start && (r_state != ST_RUN);
    assign w_run    = (r_state == ST_RUN);
    assign w_finish = w_sample && w_last;

    fa_vector_gen #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_vector_gen (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_run    (w_run),
        .o_vec    (w_vec),
        .o_sample (w_sample),
        .o_last   (w_last)
    );

    // Stimulus comes straight from the vector register, which sits at 0
    // in IDLE (reset) and DONE (wrap after vector 7).
    assign bus.a   = w_vec[2];
    assign bus.b   = w_vec[1];
    assign bus.cin = w_vec[0];

    assign w_expected = fa_expected(w_vec);
    assign w_mismatch = w_sample && ({bus.carry, bus.sum} != w_expected);

    // At most one mismatch per vector keeps the count at or below 8; the
    // clamp guards the counter against wrapping regardless.
    assign w_err_inc = (r_err_count == ERR_MAX) ? r_err_count
                                                : r_err_count + ERR_W'(1);
    assign w_err_nxt = w_mismatch ? w_err_inc : r_err_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)    w_state_nxt = ST_RUN;
            ST_RUN:  if (w_finish) w_state_nxt = ST_DONE;
            ST_DONE: if (start)    w_state_nxt = ST_RUN;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    // Result registers. Loading a run wipes the previous result; the
    // final sample folds the vector-7 outcome into pass on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_pass             <= 1'b0;
            r_err_count        <= '0;
            r_first_fail_vec   <= '0;
            r_first_fail_valid <= 1'b0;
        end else if (w_load) begin
            r_busy             <= 1'b1;
            r_done             <= 1'b0;
            r_pass             <= 1'b0;
            r_err_count        <= '0;
            r_first_fail_vec   <= '0;
            r_first_fail_valid <= 1'b0;
        end else if (w_sample) begin
            r_err_count <= w_err_nxt;
            if (w_mismatch && !r_first_fail_valid) begin
                r_first_fail_vec   <= w_vec;
                r_first_fail_valid <= 1'b1;
            end
            if (w_last) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_pass <= (w_err_nxt == '0);
            end
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail_vec   = r_first_fail_vec;
    assign first_fail_valid = r_first_fail_valid;

endmodule : full_adder_checker

// File: tb/tb_full_adder_checker.sv
`timescale 1ns/1ps

module tb_full_adder_checker;

    logic clk;
    logic rst;
    logic start1;
    logic start3;
    logic [1:0] fault;   // 0: correct adder, 1: carry stuck-at-0, 2: sum inverted
    logic use3;

    int n_cmp;
    int n_fail;

    full_adder_checker_if bus1 ();
    full_adder_checker_if bus3 ();

    logic       busy1, done1, pass1, ffvalid1;
    logic [3:0] err1;
    logic [2:0] ffv1;
    logic       busy3, done3, pass3, ffvalid3;
    logic [3:0] err3;
    logic [2:0] ffv3;

    // Behavioural adders with selectable fault.
    assign bus1.sum   = (bus1.a ^ bus1.b ^ bus1.cin) ^ (fault == 2'd2);
    assign bus1.carry = ((bus1.a & bus1.b) | (bus1.a & bus1.cin) | (bus1.b & bus1.cin)) & (fault != 2'd1);
    assign bus3.sum   = (bus3.a ^ bus3.b ^ bus3.cin) ^ (fault == 2'd2);
    assign bus3.carry = ((bus3.a & bus3.b) | (bus3.a & bus3.cin) | (bus3.b & bus3.cin)) & (fault != 2'd1);

    full_adder_checker #(.SETTLE_CYCLES(1)) dut1 (
        .clk              (clk),
        .rst              (rst),
        .start            (start1),
        .bus              (bus1),
        .busy             (busy1),
        .done             (done1),
        .pass             (pass1),
        .err_count        (err1),
        .first_fail_vec   (ffv1),
        .first_fail_valid (ffvalid1)
    );

    full_adder_checker #(.SETTLE_CYCLES(3)) dut3 (
        .clk              (clk),
        .rst              (rst),
        .start            (start3),
        .bus              (bus3),
        .busy             (busy3),
        .done             (done3),
        .pass             (pass3),
        .err_count        (err3),
        .first_fail_vec   (ffv3),
        .first_fail_valid (ffvalid3)
    );

    // Observation mux: the run task works on whichever DUT use3 selects.
    wire [2:0] obs_abc     = use3 ? {bus3.a, bus3.b, bus3.cin} : {bus1.a, bus1.b, bus1.cin};
    wire       obs_busy    = use3 ? busy3    : busy1;
    wire       obs_done    = use3 ? done3    : done1;
    wire       obs_pass    = use3 ? pass3    : pass1;
    wire [3:0] obs_err     = use3 ? err3     : err1;
    wire [2:0] obs_ffv     = use3 ? ffv3     : ffv1;
    wire       obs_ffvalid = use3 ? ffvalid3 : ffvalid1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   settle;
        int   fault_m;
        int   exp_err;
        int   exp_ffv;
        int   exp_ffvalid;
        int   exp_pass;
        int   pulse_at;   // vector index at which start is pulsed mid-run, -1 for none
        string tag;
    } run_vec_t;

    run_vec_t runs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 3) start3 = v;
        else        start1 = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy1"},    busy1,    0);
        chk({tag, " done1"},    done1,    0);
        chk({tag, " pass1"},    pass1,    0);
        chk({tag, " err1"},     err1,     0);
        chk({tag, " ffv1"},     ffv1,     0);
        chk({tag, " ffvalid1"}, ffvalid1, 0);
        chk({tag, " abc1"},     {bus1.a, bus1.b, bus1.cin}, 0);
        chk({tag, " busy3"},    busy3,    0);
        chk({tag, " done3"},    done3,    0);
        chk({tag, " err3"},     err3,     0);
        chk({tag, " abc3"},     {bus3.a, bus3.b, bus3.cin}, 0);
    endtask

    // One full run: start at edge 0, check stimulus and status after every
    // edge, then the result after edge 8*settle.
    task automatic run_check(input run_vec_t r);
        use3  = (r.settle == 3);
        fault = 2'(r.fault_m);
        @(negedge clk);
        set_start(r.settle, 1'b1);
        @(posedge clk);               // edge 0
        @(negedge clk);
        set_start(r.settle, 1'b0);
        for (int e = 0; e < 8 * r.settle; e++) begin
            chk($sformatf("%s abc e%0d", r.tag, e), obs_abc, e / r.settle);
            chk($sformatf("%s busy e%0d", r.tag, e), obs_busy, 1);
            chk($sformatf("%s done e%0d", r.tag, e), obs_done, 0);
            if (e == 0) begin
                chk({r.tag, " err cleared"},     obs_err,     0);
                chk({r.tag, " ffvalid cleared"}, obs_ffvalid, 0);
                chk({r.tag, " pass cleared"},    obs_pass,    0);
            end
            set_start(r.settle, (r.pulse_at >= 0) && (e == r.pulse_at * r.settle));
            @(posedge clk);
            @(negedge clk);
        end
        set_start(r.settle, 1'b0);
        chk({r.tag, " done"},    obs_done,    1);
        chk({r.tag, " busy"},    obs_busy,    0);
        chk({r.tag, " pass"},    obs_pass,    r.exp_pass);
        chk({r.tag, " err"},     obs_err,     r.exp_err);
        chk({r.tag, " ffvalid"}, obs_ffvalid, r.exp_ffvalid);
        if (r.exp_ffvalid != 0)
            chk({r.tag, " ffv"}, obs_ffv, r.exp_ffv);
        chk({r.tag, " abc idle"}, obs_abc, 0);
        // done must hold without a new start
        @(posedge clk);
        @(negedge clk);
        chk({r.tag, " done held"}, obs_done, 1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        fault  = 2'd0;
        use3   = 1'b0;

        //          settle fault err ffv valid pass pulse tag
        runs[0] = '{1, 0, 0, 0, 0, 1, -1, "s1_good"};
        runs[1] = '{1, 1, 4, 3, 1, 0, -1, "s1_carry0"};
        runs[2] = '{1, 2, 8, 0, 1, 0, -1, "s1_suminv"};
        runs[3] = '{1, 0, 0, 0, 0, 1, -1, "s1_b2b_good"};
        runs[4] = '{1, 0, 0, 0, 0, 1,  2, "s1_start_mid"};
        runs[5] = '{3, 0, 0, 0, 0, 1, -1, "s3_good"};
        runs[6] = '{3, 1, 4, 3, 1, 0, -1, "s3_carry0"};

        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++)
            run_check(runs[i]);

        // Reset in the middle of vector 4 aborts the run asynchronously.
        use3  = 1'b0;
        fault = 2'd0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("midrst pre abc", {bus1.a, bus1.b, bus1.cin}, 4);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        run_check('{1, 0, 0, 0, 0, 1, -1, "after_rst"});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_full_adder_checker
